// File: rtl/phase_ctrl_pkg.sv
// ============================================================================
// Module      : phase_ctrl_pkg
// Description : Shared state encoding, stage enables, memwrite codes and the
//               halt-instruction constants for the phase controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package phase_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [4:0] c_phase_none   = 5'b00000;
  localparam logic [4:0] c_phase_fetch  = 5'b00001;
  localparam logic [4:0] c_phase_decode = 5'b00010;
  localparam logic [4:0] c_phase_exec   = 5'b00100;
  localparam logic [4:0] c_phase_mem    = 5'b01000;
  localparam logic [4:0] c_phase_wb     = 5'b10000;

  localparam logic [1:0] c_mw_none  = 2'b00;
  localparam logic [1:0] c_mw_read  = 2'b01;
  localparam logic [1:0] c_mw_store = 2'b10;

  localparam logic [1:0] c_hlt_class  = 2'b11;
  localparam logic [3:0] c_hlt_opcode = 4'hF;

  function automatic logic is_hlt(input logic [1:0] cls, input logic [3:0] opc);
    return (cls == c_hlt_class) && (opc == c_hlt_opcode);
  endfunction

  // Code 11 is reserved and behaves like "no memory access".
  function automatic logic is_mem_access(input logic [1:0] mw);
    return (mw == c_mw_read) || (mw == c_mw_store);
  endfunction

endpackage

`default_nettype wire

// File: rtl/phase_ctrl_wrap_counter.sv
// ============================================================================
// Module      : wrap_counter
// Description : Free-running modulo-2^WIDTH counter with synchronous
//               active-low clear and count enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wrap_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/phase_ctrl.sv
// ============================================================================
// Module      : phase_ctrl
// Description : Multi-cycle instruction sequencer driving one-hot stage
//               enables, memory handshake and a retired-instruction count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_ctrl
  import phase_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      command,
  input  logic [1:0]       memwrite,
  input  logic             writereg,
  input  logic             mem_ready,
  output logic [4:0]       phase_en,
  output logic             mem_req,
  output logic             pc_write,
  output logic             reg_write_en,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  state_t r_state;
  state_t w_next;
  logic   w_hlt;
  logic   w_mem_access;
  logic   w_retire;

  assign w_hlt        = is_hlt(command[15:14], command[7:4]);
  assign w_mem_access = is_mem_access(memwrite);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start)      w_next = S_FETCH;
      S_FETCH:  if (mem_ready)  w_next = S_DECODE;
      S_DECODE: w_next = w_hlt ? S_HALT : S_EXEC;
      S_EXEC:   w_next = w_mem_access ? S_MEM : S_WB;
      S_MEM:    if (mem_ready)  w_next = S_WB;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs decode the state register only; writereg qualifies the WB strobe.
  always_comb begin
    phase_en     = c_phase_none;
    mem_req      = 1'b0;
    pc_write     = 1'b0;
    reg_write_en = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;
    w_retire     = 1'b0;
    unique case (r_state)
      S_IDLE: ;
      S_FETCH: begin
        phase_en = c_phase_fetch;
        mem_req  = 1'b1;
        busy     = 1'b1;
      end
      S_DECODE: begin
        phase_en = c_phase_decode;
        busy     = 1'b1;
      end
      S_EXEC: begin
        phase_en = c_phase_exec;
        busy     = 1'b1;
      end
      S_MEM: begin
        phase_en = c_phase_mem;
        mem_req  = 1'b1;
        busy     = 1'b1;
      end
      S_WB: begin
        phase_en     = c_phase_wb;
        pc_write     = 1'b1;
        reg_write_en = writereg;
        busy         = 1'b1;
        w_retire     = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  wrap_counter #(
    .WIDTH (CNT_W)
  ) u_instr_counter (
    .clock   (clock),
    .clear_n (reset_n),
    .enable  (w_retire),
    .count   (instr_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_phase_ctrl.sv
// ============================================================================
// Module      : tb_phase_ctrl
// Description : Directed self-checking bench for phase_ctrl; a 4-bit and a
//               default-width instance share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phase_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] command;
  logic [1:0]  memwrite;
  logic        writereg;
  logic        mem_ready;

  logic [4:0]  phase_en,     phase_en_w;
  logic        mem_req,      mem_req_w;
  logic        pc_write,     pc_write_w;
  logic        reg_write_en, reg_write_en_w;
  logic        busy,         busy_w;
  logic        halted,       halted_w;
  logic [3:0]  instr_count;
  logic [15:0] instr_count_w;

  int checks = 0;
  int passed = 0;
  int pc_pulses = 0;

  always #5 clock = ~clock;

  phase_ctrl #(.CNT_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .command(command),
    .memwrite(memwrite), .writereg(writereg), .mem_ready(mem_ready),
    .phase_en(phase_en), .mem_req(mem_req), .pc_write(pc_write),
    .reg_write_en(reg_write_en), .busy(busy), .halted(halted),
    .instr_count(instr_count)
  );

  phase_ctrl dut_w (
    .clock(clock), .reset_n(reset_n), .start(start), .command(command),
    .memwrite(memwrite), .writereg(writereg), .mem_ready(mem_ready),
    .phase_en(phase_en_w), .mem_req(mem_req_w), .pc_write(pc_write_w),
    .reg_write_en(reg_write_en_w), .busy(busy_w), .halted(halted_w),
    .instr_count(instr_count_w)
  );

  always @(posedge clock) if (pc_write) pc_pulses++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic alu_instr();
    command = 16'hC000; memwrite = 2'b00; writereg = 1'b1; mem_ready = 1'b1;
    repeat (4) tick();
  endtask

  int p0;

  initial begin
    reset_n = 1'b0; start = 1'b0; command = 16'h0000;
    memwrite = 2'b00; writereg = 1'b0; mem_ready = 1'b0;
    repeat (2) tick();
    check("rst_phase", {27'd0, phase_en}, 32'h0);
    check("rst_flags", {mem_req, pc_write, reg_write_en, busy, halted}, 32'h0);
    check("rst_count", instr_count_w, 32'h0);

    reset_n = 1'b1;
    tick();
    check("idle_hold", {busy, phase_en}, 32'h0);

    // ALU instruction C000
    start = 1'b1; command = 16'hC000; writereg = 1'b1; mem_ready = 1'b1;
    tick();
    check("alu_fetch", {busy, mem_req, phase_en}, {26'd0, 2'b11, 5'b00001});
    start = 1'b0;
    tick();
    check("alu_decode", phase_en, 32'b00010);
    tick();
    check("alu_exec", phase_en, 32'b00100);
    tick();
    check("alu_wb", {pc_write, reg_write_en, phase_en}, {25'd0, 2'b11, 5'b10000});
    tick();
    check("alu_count", instr_count_w, 32'd1);
    check("alu_refetch", phase_en, 32'b00001);

    // Load with three wait cycles in MEM: 8 cycles in total
    p0 = pc_pulses;
    command = 16'h1234; memwrite = 2'b01; writereg = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    check("ld_mem", {mem_req, phase_en}, {26'd0, 1'b1, 5'b01000});
    tick(); tick(); tick();
    check("ld_mem_wait3", phase_en, 32'b01000);
    mem_ready = 1'b1;
    tick();
    check("ld_wb", {reg_write_en, phase_en}, {26'd0, 1'b1, 5'b10000});
    tick();
    check("ld_fetch_at8", phase_en, 32'b00001);
    check("ld_pc_pulses", pc_pulses - p0, 32'd1);
    check("ld_count", instr_count_w, 32'd2);

    // Store, no register write
    memwrite = 2'b10; writereg = 1'b0; command = 16'h4321;
    tick(); tick(); tick();
    check("st_mem", phase_en, 32'b01000);
    tick();
    check("st_wb", {pc_write, reg_write_en, phase_en}, {25'd0, 2'b10, 5'b10000});
    tick();
    check("st_count", instr_count_w, 32'd3);

    // memwrite=11 behaves as no access
    memwrite = 2'b11; writereg = 1'b1;
    tick(); tick(); tick();
    check("mw11_skip_mem", phase_en, 32'b10000);
    tick();

    // FETCH wait, start ignored, then reset mid-wait
    mem_ready = 1'b0; start = 1'b1;
    tick(); tick();
    check("fetch_wait", {mem_req, phase_en}, {26'd0, 1'b1, 5'b00001});
    check("pre_rst_count", instr_count_w, 32'd4);
    reset_n = 1'b0;
    tick();
    check("fwait_rst_idle", {busy, mem_req, phase_en}, 32'h0);
    check("fwait_rst_count", instr_count_w, 32'd0);

    // One ALU then HLT: count stays 1, HALT is sticky
    reset_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    alu_instr();
    command = 16'hC0F0; memwrite = 2'b00;
    tick();
    check("hlt_decode", phase_en, 32'b00010);
    tick();
    check("hlt_state", {halted, busy, pc_write, mem_req, phase_en}, {23'd0, 4'b1000, 5'b0});
    start = 1'b1;
    tick(); tick();
    check("hlt_sticky", halted, 32'd1);
    check("hlt_count", instr_count_w, 32'd1);
    reset_n = 1'b0;
    tick();
    check("hlt_rst", {halted, busy}, 32'h0);

    // 16 ALU instructions: 4-bit counter wraps, 16-bit does not
    reset_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) alu_instr();
    check("wrap_15", instr_count, 32'd15);
    alu_instr();
    check("wrap_0", instr_count, 32'd0);
    check("wide_16", instr_count_w, 32'd16);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
